// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds PC and IR and runs the IDLE/REQ/VALID handshake
// with instruction memory. Each rising edge of PC_WRITE launches one fetch.
// Optional build macro FETCH_TIMEOUT_EN adds a 255-cycle request timeout that
// substitutes a noop and raises the sticky FETCH_ERR flag.
module fetch_unit (
    input  logic        CLK,
    input  logic        RST_F,
    input  logic        PC_WRITE,
    input  logic        PC_SEL,
    input  logic        BR_SEL,
    input  logic        PC_RST,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    output logic        IMEM_REQ,
    output logic [15:0] IMEM_ADDR,
    output logic [3:0]  OPCODE,
    output logic [3:0]  MM,
    output logic [15:0] IMM,
    output logic [15:0] PC_OUT,
    output logic        IR_VALID,
    output logic        HALTED,
    output logic        FETCH_ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic        [15:0] pc;
    logic        [15:0] pc_next;
    logic        [31:0] ir;
    logic               pc_write_q;
    logic               first_fetch;
    logic               halted;
    logic               launch;
    logic               ack_load;
    logic               timeout;
    logic signed [15:0] imm_s;
    logic signed [15:0] pc_rel;
    logic               unused_ir;

    // Relative branch target: PC plus sign-extended immediate, wrapping mod 2^16
    assign imm_s     = $signed(ir[15:0]);
    assign pc_rel    = $signed(pc) + imm_s;
    assign unused_ir = ^ir[23:16];

    // Select the PC value taken on a launch
    always_comb begin
        pc_next = pc + 16'd1;
        if (PC_SEL) begin
            pc_next = BR_SEL ? $unsigned(pc_rel) : ir[15:0];
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] to_cnt;
    logic       fetch_err;

    // 255th request cycle without an acknowledge ends the fetch
    assign timeout   = (state == REQ) && !IMEM_ACK && (to_cnt == 8'd254);
    assign FETCH_ERR = fetch_err;

    // Count cycles spent waiting in REQ; cleared whenever the wait ends
    always_ff @(posedge CLK) begin
        if (!RST_F || PC_RST) begin
            to_cnt <= 8'd0;
        end else if ((state == REQ) && !IMEM_ACK && !timeout) begin
            to_cnt <= to_cnt + 8'd1;
        end else begin
            to_cnt <= 8'd0;
        end
    end

    // Sticky timeout flag, cleared only by RST_F
    always_ff @(posedge CLK) begin
        if (!RST_F) begin
            fetch_err <= 1'b0;
        end else if (timeout && !PC_RST) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign FETCH_ERR = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (!RST_F) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, launch/load strobes and handshake outputs
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        ack_load  = 1'b0;
        IMEM_REQ  = 1'b0;
        IR_VALID  = 1'b0;
        case (state)
            IDLE: begin
                if (PC_WRITE && !pc_write_q && !halted) begin
                    launch    = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                IMEM_REQ = 1'b1;
                if (IMEM_ACK) begin
                    ack_load  = 1'b1;
                    state_nxt = VALID;
                end else if (timeout) begin
                    state_nxt = VALID;
                end
            end
            VALID: begin
                IR_VALID  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // PC clear overrides any launch or acknowledge in the same cycle
        if (PC_RST) begin
            state_nxt = IDLE;
            launch    = 1'b0;
            ack_load  = 1'b0;
        end
    end

    // PC, IR, first-fetch and halt tracking
    always_ff @(posedge CLK) begin
        if (!RST_F) begin
            pc          <= 16'd0;
            ir          <= 32'd0;
            first_fetch <= 1'b1;
            halted      <= 1'b0;
            pc_write_q  <= 1'b0;
        end else begin
            pc_write_q <= PC_WRITE;
            if (PC_RST) begin
                pc          <= 16'd0;
                first_fetch <= 1'b1;
                halted      <= 1'b0;
            end else begin
                if (launch) begin
                    first_fetch <= 1'b0;
                    if (!first_fetch) begin
                        pc <= pc_next;
                    end
                end
                if (ack_load) begin
                    ir <= IMEM_DATA;
                    if (IMEM_DATA[31:28] == 4'hF) begin
                        halted <= 1'b1;
                    end
                end else if (timeout) begin
                    ir <= 32'd0;
                end
            end
        end
    end

    assign IMEM_ADDR = pc;
    assign PC_OUT    = pc;
    assign OPCODE    = ir[31:28];
    assign MM        = ir[27:24];
    assign IMM       = ir[15:0];
    assign HALTED    = halted;

endmodule
